// File: rtl/io_map_pkg.sv
// Shared register map of the I/O peripheral window.
// Latency: n/a (constants only).
// Backpressure: n/a.
package io_map_pkg;

    // Default base of the 64-byte peripheral window (bits [5:0] zero).
    localparam logic [15:0] IO_BASE_ADDR = 16'hFF00;

    // Register offsets, selected by address[5:3].
    localparam logic [2:0] OFF_SW        = 3'd0;
    localparam logic [2:0] OFF_BTN_LEVEL = 3'd1;
    localparam logic [2:0] OFF_BTN_EVENT = 3'd2;
    localparam logic [2:0] OFF_LEDS      = 3'd3;
    localparam logic [2:0] OFF_HEX       = 3'd4;
    localparam logic [2:0] OFF_CYCLES    = 3'd5;

endpackage

// File: rtl/button_debouncer.sv
// Single-button 2-flop synchroniser plus level debouncer with rise pulse.
// Latency: level accepted DEBOUNCE_CYCLES edges after the synced input settles (2 sync edges first).
// Backpressure: none; free-running.
//
// Ports: clock, reset (async active-low), btn_raw (asynchronous, active-high),
//        level (accepted level), rise (high in the cycle whose edge accepts a 0->1 change).
module button_debouncer
    import io_map_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        level_q, level_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = btn_raw;
        s2_d    = s1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        if (s2_q == level_q) begin
            // Any sample agreeing with the accepted level restarts the run.
            cnt_d = 16'd0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            level_d = ~level_q;
            cnt_d   = 16'd0;
            rise    = ~level_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/io_peripheral_responder.sv
// Memory-mapped peripheral responder: LED/HEX registers, switches, debounced buttons, cycle counter.
// Latency: P_data/hit registered, 1 cycle after the address; writes land on the strobe edge.
// Backpressure: none; CPU stores and loads always complete.
//
// Ports: clock, reset (async active-low), address/wr_data/write (CPU bus),
//        SW/button (raw board inputs), P_data/hit (read path), leds/hex_value (board outputs).
module io_peripheral_responder
    import io_map_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR       = IO_BASE_ADDR,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SW_W            = 10,
    parameter int          BTN_W           = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      address,
    input  logic [63:0]      wr_data,
    input  logic             write,
    input  logic [SW_W-1:0]  SW,
    input  logic [BTN_W-1:0] button,
    output logic [63:0]      P_data,
    output logic             hit,
    output logic [31:0]      leds,
    output logic [15:0]      hex_value
);

    logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [31:0]      leds_q, leds_d;
    logic [15:0]      hex_q, hex_d;
    logic [BTN_W-1:0] event_q, event_d;
    logic [63:0]      cycles_q, cycles_d;
    logic [63:0]      p_data_q, p_data_d;
    logic             hit_q, hit_d;

    logic [BTN_W-1:0] btn_level, btn_rise, clr_mask;
    logic [63:0]      rd_data;
    logic [2:0]       offset;
    logic             in_win, wr_en;

    // Only the low word of the write data and the doubleword offset matter.
    logic unused_bits;
    assign unused_bits = &{1'b0, wr_data[63:32], address[2:0]};

    for (genvar n = 0; n < BTN_W; n++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock  (clock),
            .reset  (reset),
            .btn_raw(button[n]),
            .level  (btn_level[n]),
            .rise   (btn_rise[n])
        );
    end

    always_comb begin
        in_win = (address[15:6] == BASE_ADDR[15:6]);
        offset = address[5:3];
        wr_en  = write & in_win;

        sw_s1_d = SW;
        sw_s2_d = sw_s1_q;

        leds_d = leds_q;
        if (wr_en && offset == OFF_LEDS) leds_d = wr_data[31:0];
        hex_d = hex_q;
        if (wr_en && offset == OFF_HEX) hex_d = wr_data[15:0];

        // A rise in the same cycle as its W1C keeps the flag set.
        clr_mask = (wr_en && offset == OFF_BTN_EVENT) ? wr_data[BTN_W-1:0] : '0;
        event_d  = (event_q & ~clr_mask) | btn_rise;

        cycles_d = cycles_q + 64'd1;

        // Read mux sees register state before this edge's write.
        rd_data = 64'd0;
        case (offset)
            OFF_SW:        rd_data = 64'(sw_s2_q);
            OFF_BTN_LEVEL: rd_data = 64'(btn_level);
            OFF_BTN_EVENT: rd_data = 64'(event_q);
            OFF_LEDS:      rd_data = 64'(leds_q);
            OFF_HEX:       rd_data = 64'(hex_q);
            OFF_CYCLES:    rd_data = cycles_q;
            default:       rd_data = 64'd0;
        endcase
        p_data_d = in_win ? rd_data : 64'd0;
        hit_d    = in_win;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            leds_q   <= 32'd0;
            hex_q    <= 16'd0;
            event_q  <= '0;
            cycles_q <= 64'd0;
            p_data_q <= 64'd0;
            hit_q    <= 1'b0;
        end else begin
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            leds_q   <= leds_d;
            hex_q    <= hex_d;
            event_q  <= event_d;
            cycles_q <= cycles_d;
            p_data_q <= p_data_d;
            hit_q    <= hit_d;
        end
    end

    assign P_data    = p_data_q;
    assign hit       = hit_q;
    assign leds      = leds_q;
    assign hex_value = hex_q;

endmodule

// File: doc/io_peripheral_responder.md
Name: io_peripheral_responder

Overview:
- Memory-mapped peripheral responder on the CPU data bus; the device end of the CPU's address/data/write interface.
- Decodes CPU writes into the LED and hex-display registers.
- Returns switch, debounced button, button-event and cycle-counter state on the P_data read path.
- Sits between the CPU instance and the DE0 board I/O in the top level; replaces the unconnected P_data net.

Parameters:
BASE_ADDR, 16'hFF00, base of the 64-byte peripheral window; bits [5:0] must be zero
DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required before a button level is accepted; legal range 1..65535
SW_W, 10, number of slide switches
BTN_W, 3, number of push buttons

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset
address  in  16  CPU byte address
wr_data  in  64  CPU write data (CPU_data)
write  in  1  CPU write strobe, one cycle per store
SW  in  SW_W  raw slide switches, asynchronous
button  in  BTN_W  raw buttons, already inverted to active-high, asynchronous
P_data  out  64  registered read data to the CPU
hit  out  1  registered; previous-cycle address was inside the window
leds  out  32  LED register
hex_value  out  16  value for the quad 7-segment decoder

Behaviour:
- Window: address[15:6] == BASE_ADDR[15:6]. Register offset = address[5:3]. address[2:0] are ignored.
- Register map by offset:
  - 0 SW: read-only, zero-extended 2-flop-synchronised switches.
  - 1 BTN_LEVEL: read-only, zero-extended debounced levels.
  - 2 BTN_EVENT: sticky rising-edge flags; write-1-to-clear on wr_data[BTN_W-1:0].
  - 3 LEDS: read/write, bits [31:0]; upper read bits are 0.
  - 4 HEX: read/write, bits [15:0]; upper read bits are 0.
  - 5 CYCLES: read-only, 64-bit free-running counter; wraps from all-ones to 0.
  - 6, 7: read as 0; writes ignored.
- Read latency: P_data and hit update every cycle from the current address, giving 1-cycle latency. Outside the window, P_data = 0 and hit = 0.
- Read-during-write to the same register: P_data returns the pre-write value; the new value is visible one cycle later.
- Writes take effect on the clock edge where write = 1 and the address is in the window. Writes to read-only registers are ignored.
- Synchroniser: SW and button each pass through 2 flops before any use.
- Debounce, per button:
  - Each button has a 16-bit counter and an accepted level.
  - If the synced input equals the accepted level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - Result: a new level is accepted after DEBOUNCE_CYCLES consecutive differing samples. A single glitch sample resets the count.
- Event logic:
  - Accepted level 0->1 sets BTN_EVENT[n].
  - A 1->0 transition has no event.
  - If a set and a W1C of the same bit occur in the same cycle, the set wins.
- Reset (asynchronous assert, any time including mid-debounce): all of the following go to 0 — P_data, hit, leds, hex_value, BTN_EVENT, debounce counters, accepted levels, synchroniser flops, cycle counter.
- Deassertion: the first counter increment occurs on the first rising edge after reset is released.

Decomposition:
- Shared package io_map_pkg holds:
  - offset constants OFF_SW=0, OFF_BTN_LEVEL=1, OFF_BTN_EVENT=2, OFF_LEDS=3, OFF_HEX=4, OFF_CYCLES=5
  - the default BASE_ADDR
- One sub-module, button_debouncer (one instance per button), contains:
  - 2-flop synchroniser, counter and accepted level
  - rise pulse output
- The top module holds decode, registers, cycle counter and the read mux.

Test Plan:
1. Reset then release, DEBOUNCE_CYCLES=4, address=16'hFF28 -> P_data=0 on the first cycle after release. P_data increments by 1 each following cycle; hit=1.
2. Write 64'h0000_0000_DEAD_BEEF to 16'hFF18 and 64'h1234 to 16'hFF20 -> leds=32'hDEADBEEF and hex_value=16'h1234 the next cycle. Reading 16'hFF18 returns 64'h0000_0000_DEAD_BEEF after 1 cycle. A write to 16'hFF00 leaves the SW value unchanged.
3. Set button[1]=1 and hold, DEBOUNCE_CYCLES=4 -> BTN_LEVEL reads 3'b010 and BTN_EVENT reads 3'b010 once the level is accepted (2 sync + 4 debounce cycles). A 1-cycle glitch on button[0] never sets a level or event.
4. Write 64'h2 to 16'hFF10 with no new edge -> BTN_EVENT becomes 0. W1C of bit 1 in the same cycle as a new button[1] rise -> bit 1 stays 1.
5. SW=10'h3A5 -> reading 16'hFF00 gives 64'h3A5 (after the sync delay). Reading 16'hFF30 or 16'h0100 gives P_data=0; hit is 1 for the former and 0 for the latter.
6. Assert reset mid-debounce and with leds nonzero -> all outputs are 0 immediately without a clock edge. After release, the held button requires a full DEBOUNCE_CYCLES again before it is accepted.
